// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for irq_ctrl: register map, source limit and priority encoder.
package irq_ctrl_pkg;

    localparam int MAX_SRC = 32;

    localparam logic [3:0] REG_PENDING  = 4'd0;
    localparam logic [3:0] REG_ENABLE   = 4'd1;
    localparam logic [3:0] REG_MODE     = 4'd2;
    localparam logic [3:0] REG_CLAIM    = 4'd3;
    localparam logic [3:0] REG_RAW      = 4'd4;
    localparam logic [3:0] REG_POLARITY = 4'd5;

    // Lowest set index wins; result is index+1 so that 0 means "nothing active".
    function automatic logic [5:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [5:0] id;
        id = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) id = 6'(i + 1);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One-bit multi-flop synchroniser for an asynchronous interrupt request.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// N_SRC-line maskable interrupt controller feeding cp0, with a word-addressed IO register window.
// Optional per-source input inversion register enabled by `define IRQ_CTRL_POLARITY_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [3:0]       A,
    input  logic [31:0]      WD,
    input  logic             WE,
    input  logic             RE,
    output logic [31:0]      RD,
    output logic             INTERRUPT,
    output logic [5:0]       IRQ_ID
);

    // Registers are held 32 bits wide; bits at or above N_SRC are forced to zero by SRC_MASK.
    localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF >> (MAX_SRC - N_SRC);

    logic [N_SRC-1:0] sync_q;
    logic [31:0]      sig;
    logic [31:0]      prev;
    logic [31:0]      rise;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;
    logic [31:0]      enable;
    logic [31:0]      mode;
    logic [31:0]      active;
    logic [31:0]      wd_src;
    logic [31:0]      w1c_vec;
    logic [31:0]      claim_vec;
    logic [31:0]      mode_chg;
    logic [31:0]      rd_val;
    logic             wr_pend;
    logic             wr_en;
    logic             wr_mode;
    logic             claim_rd;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (CLK),
            .rst_n(RESET_N),
            .d    (IRQ_IN[g]),
            .q    (sync_q[g])
        );
    end

`ifdef IRQ_CTRL_POLARITY_EN
    logic [31:0] polarity;
    logic        wr_pol;

    assign wr_pol = WE && (A == REG_POLARITY);
    assign sig    = 32'(sync_q) ^ polarity;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)    polarity <= '0;
        else if (wr_pol) polarity <= wd_src;
    end
`else
    assign sig = 32'(sync_q);
`endif

    // WE and RE are single-cycle strobes sampled at the rising edge; no handshake or backpressure,
    // every strobe is accepted in the cycle it is presented and RD answers on the following cycle.
    assign wd_src   = WD & SRC_MASK;
    assign wr_pend  = WE && (A == REG_PENDING);
    assign wr_en    = WE && (A == REG_ENABLE);
    assign wr_mode  = WE && (A == REG_MODE);
    assign claim_rd = RE && (A == REG_CLAIM);

    assign rise     = sig & ~prev;
    assign active   = pending & enable;
    assign w1c_vec  = wr_pend ? wd_src : '0;
    assign mode_chg = wr_mode ? (wd_src ^ mode) : '0;

    always_comb begin
        claim_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_vec[i] = claim_rd && (IRQ_ID == 6'(i + 1));
        end
    end

    // Edge bits: a new rise beats a same-cycle clear. Level bits track the input.
    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_chg[i])
                pending_nxt[i] = 1'b0;
            else if (mode[i])
                pending_nxt[i] = (pending[i] & ~(w1c_vec[i] | claim_vec[i])) | rise[i];
            else
                pending_nxt[i] = sig[i];
        end
    end

    always_comb begin
        rd_val = '0;
        case (A)
            REG_PENDING:  rd_val = pending;
            REG_ENABLE:   rd_val = enable;
            REG_MODE:     rd_val = mode;
            REG_CLAIM:    rd_val = {26'b0, IRQ_ID};
            REG_RAW:      rd_val = sig;
`ifdef IRQ_CTRL_POLARITY_EN
            REG_POLARITY: rd_val = polarity;
`endif
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev      <= '0;
            pending   <= '0;
            enable    <= '0;
            mode      <= '0;
            RD        <= '0;
            INTERRUPT <= 1'b0;
            IRQ_ID    <= '0;
        end else begin
            prev      <= sig;
            pending   <= pending_nxt;
            if (wr_en)   enable <= wd_src;
            if (wr_mode) mode   <= wd_src;
            if (RE)      RD     <= rd_val;
            INTERRUPT <= |active;
            IRQ_ID    <= prio_enc(active);
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: 8-source main instance plus 32- and 1-source corner instances.
module tb_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [7:0]  irq8;
    logic [31:0] irq32;
    logic [0:0]  irq1;
    logic [3:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [31:0] rd8, rd32, rd1;
    logic        int8, int32, int1;
    logic [5:0]  id8, id32, id1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 CLK = ~CLK;

    irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) u8 (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(irq8), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .RD(rd8), .INTERRUPT(int8), .IRQ_ID(id8)
    );

    irq_ctrl #(.N_SRC(32), .SYNC_STAGES(2)) u32 (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(irq32), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .RD(rd32), .INTERRUPT(int32), .IRQ_ID(id32)
    );

    irq_ctrl #(.N_SRC(1), .SYNC_STAGES(2)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .IRQ_IN(irq1), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .RD(rd1), .INTERRUPT(int1), .IRQ_ID(id1)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic re, input logic [3:0] addr,
                       input logic [31:0] wd, input int sel, input logic [31:0] exp,
                       input string tag);
        logic [31:0] obs;
        if (re) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        WE = we; RE = re; A = addr; WD = wd;
        tick(1);
        WE = 1'b0; RE = 1'b0;
        if (re) begin
            obs = (sel == 32) ? rd32 : (sel == 1) ? rd1 : rd8;
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        bus(1'b1, 1'b0, addr, wd, 8, 32'h0, "");
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag,
                      input int sel = 8);
        bus(1'b0, 1'b1, addr, 32'h0, sel, exp, tag);
    endtask

    initial begin
        WE = 1'b0; RE = 1'b0; A = '0; WD = '0;
        irq8 = 8'hFF; irq32 = '0; irq1 = '0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        check("rst_int", 32'(int8), 32'h0);
        check("rst_id", 32'(id8), 32'h0);
        check("rst_rd", rd8, 32'h0);

        // Level-mode sources held high, then an asynchronous reset mid-run
        tick(4);
        wr(4'd1, 32'hFF);
        tick(1);
        check("pre_rst_int", 32'(int8), 32'h1);
        check("pre_rst_id", 32'(id8), 32'h1);
        rd(4'd4, 32'hFF, "pre_rst_raw");
        RESET_N = 1'b0;
        #1;
        check("async_rst_int", 32'(int8), 32'h0);
        check("async_rst_id", 32'(id8), 32'h0);
        check("async_rst_rd", rd8, 32'h0);
        #3 RESET_N = 1'b1;
        tick(4);
        rd(4'd0, 32'hFF, "post_rst_pend");
        rd(4'd4, 32'hFF, "post_rst_raw");
        rd(4'd1, 32'h0, "post_rst_en");
        check("post_rst_int", 32'(int8), 32'h0);

        // Edge mode and priority
        irq8 = 8'h00;
        tick(4);
        wr(4'd2, 32'hFF);
        bus(1'b1, 1'b1, 4'd1, 32'h28, 8, 32'h0, "we_re_prewrite");
        rd(4'd1, 32'h28, "en_readback");
        irq8 = 8'h20; tick(2);
        irq8 = 8'h08; tick(2);
        irq8 = 8'h00; tick(4);
        check("edge_int", 32'(int8), 32'h1);
        check("edge_id", 32'(id8), 32'h4);
        rd(4'd3, 32'h4, "claim1");
        tick(1);
        check("next_id", 32'(id8), 32'h6);
        rd(4'd3, 32'h6, "claim2");
        check("int_hold", 32'(int8), 32'h1);
        tick(1);
        check("int_fall", 32'(int8), 32'h0);
        check("id_none", 32'(id8), 32'h0);
        check("rd_hold", rd8, 32'h6);
        rd(4'd0, 32'h0, "pend_cleared");

        // Disabled source still latches; enabling raises INTERRUPT; W1C clears
        irq8 = 8'h01; tick(2);
        irq8 = 8'h00; tick(4);
        check("dis_int", 32'(int8), 32'h0);
        rd(4'd0, 32'h01, "dis_pend");
        wr(4'd1, 32'h29);
        tick(1);
        check("en_int", 32'(int8), 32'h1);
        check("en_id", 32'(id8), 32'h1);
        wr(4'd0, 32'h01);
        tick(1);
        check("w1c_int", 32'(int8), 32'h0);

        // Level mode latency and W1C immunity
        wr(4'd2, 32'h00);
        wr(4'd1, 32'h01);
        irq8 = 8'h01;
        tick(3);
        check("lvl_early", 32'(int8), 32'h0);
        tick(1);
        check("lvl_rise", 32'(int8), 32'h1);
        wr(4'd0, 32'h01);
        rd(4'd0, 32'h01, "lvl_w1c");
        irq8 = 8'h00;
        tick(3);
        check("lvl_hold", 32'(int8), 32'h1);
        tick(1);
        check("lvl_fall", 32'(int8), 32'h0);

        // Set/clear collision on an edge bit
        wr(4'd2, 32'h04);
        irq8 = 8'h04;
        tick(2);
        wr(4'd0, 32'h04);
        rd(4'd0, 32'h04, "collide");
        wr(4'd0, 32'h04);
        rd(4'd0, 32'h00, "w1c_edge");
        irq8 = 8'h00;

        // Width corners
        wr(4'd1, 32'hFFFF_FFFF);
        rd(4'd1, 32'h1, "en_n1", 1);
        rd(4'd1, 32'hFFFF_FFFF, "en_n32", 32);
        rd(4'd1, 32'hFF, "en_n8", 8);
        wr(4'd2, 32'h0);
        irq32 = 32'h8000_0000;
        tick(4);
        check("id32", 32'(id32), 32'd32);
        check("int32", 32'(int32), 32'h1);
        rd(4'd3, 32'd32, "claim32", 32);
        rd(4'd7, 32'h0, "a7_n8", 8);
        rd(4'd7, 32'h0, "a7_n1", 1);
        irq32 = '0;

`ifdef IRQ_CTRL_POLARITY_EN
        wr(4'd2, 32'h01);
        wr(4'd5, 32'h01);
        tick(4);
        rd(4'd5, 32'h01, "pol_reg");
        rd(4'd0, 32'h01, "pol_pend");
        rd(4'd4, 32'h01, "pol_raw");
`else
        rd(4'd5, 32'h0, "a5_nopol");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised interrupt controller that replaces the single push-button interrupt source feeding CP0 with N_SRC independent, individually maskable lines. It synchronises asynchronous requests and latches edge- or level-mode pending state. It drives the single INTERRUPT input of cp0 and exposes a word-addressed register window on the IO bus, so the exception handler can identify and acknowledge the source.

## Interface
- N_SRC, 8, number of interrupt sources, legal 1..32
- SYNC_STAGES, 2, synchroniser depth per source, legal 2..4
- CLK  in  1  system clock, all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- IRQ_IN  in  N_SRC  raw asynchronous requests, active high
- A  in  4  register word address
- WD  in  32  write data
- WE  in  1  write strobe, one-cycle
- RE  in  1  read strobe, one-cycle
- RD  out  32  registered read data
- INTERRUPT  out  1  to cp0, registered OR of (PENDING & ENABLE)
- IRQ_ID  out  6  registered id of highest-priority active source, index+1; 0 = none

## Operation
- Registers, bits above N_SRC read 0 and ignore writes:
  - A=0 PENDING: read; write-1-to-clear, edge-mode bits only.
  - A=1 ENABLE: RW.
  - A=2 MODE: RW; 1 = edge, 0 = level.
  - A=3 CLAIM: read returns {26'b0, IRQ_ID}; the read clears that source's PENDING bit if it is edge-mode; writes ignored.
  - A=4 RAW: synchronised inputs, read-only.
  - Other addresses read 0.
- Each source passes through SYNC_STAGES flops. It then goes through a polarity stage (see Configuration), then a one-flop edge detector.
- Edge mode: a rise of the synchronised signal sets PENDING; it stays set until W1C or claim.
- Level mode: PENDING = synchronised signal each cycle; W1C and claim have no effect.
- MODE change: PENDING for that bit clears on the write cycle; detector history is kept, so no spurious edge occurs.
- Priority: lowest index wins. IRQ_ID and CLAIM consider only PENDING & ENABLE.
- Disabled sources still latch PENDING; enabling later raises INTERRUPT.
- Simultaneous set and clear (edge arrives in the same cycle as W1C or claim of that bit): set wins, and the bit stays pending.
- WE and RE in the same cycle: both act; read returns pre-write value.
- Reset values: all registers 0, synchroniser and detector flops 0, RD=0, INTERRUPT=0, IRQ_ID=0. Reset asserted mid-operation clears everything immediately (asynchronous), including PENDING.

## Timing
- Source stable high before edge 0 → PENDING bit visible after edge SYNC_STAGES. INTERRUPT and IRQ_ID follow after edge SYNC_STAGES+1.
- RD is valid the cycle after RE and is held until the next RE.
- Register writes take effect at the WE edge. INTERRUPT reflects the change one edge later.
- Claim at edge k clears PENDING at edge k. INTERRUPT drops after edge k+1 if no other source is active.
- Minimum detectable pulse: longer than one CLK period. Shorter pulses may be lost.
- No combinational path from any input to any output.

## Configuration
- IRQ_CTRL_POLARITY_EN defined:
  - Adds POLARITY register at A=5, RW, reset 0.
  - A 1 inverts that source after synchronisation, making it active-low.
  - RAW shows the post-inversion value.
- Undefined: A=5 reads 0, and all sources are active-high.

## Structure
- Package irq_ctrl_pkg holds:
  - register address localparams (REG_PENDING..REG_POLARITY);
  - MAX_SRC = 32;
  - function for priority encode (vector → index+1).
- Sub-module irq_sync: one-bit SYNC_STAGES-deep synchroniser with async active-low reset, instantiated N_SRC times via generate.
- Top holds register file, edge detect, pending logic, priority encoder and output flops.

## Test plan
- Reset: with IRQ_IN=8'hFF held, assert RESET_N low mid-run → all outputs 0 immediately. After release with ENABLE=0, PENDING reads 8'hFF, RAW 8'hFF, INTERRUPT stays 0.
- Edge mode, priority:
  - Setup: MODE=8'hFF, ENABLE=8'h28.
  - Stimulus: pulse IRQ_IN[5], then IRQ_IN[3].
  - Response: IRQ_ID=4, CLAIM read returns 4, next IRQ_ID=6, second claim returns 6, INTERRUPT falls 1 cycle later.
- Level mode: MODE=0, ENABLE=1, IRQ_IN[0] high → INTERRUPT after SYNC_STAGES+1 edges. W1C 1 to PENDING → still set. Drop input → INTERRUPT low SYNC_STAGES+1 edges later.
- Set/clear collision: edge on bit 2 synchronised in the same cycle as W1C 8'h04 → PENDING[2] remains 1.
- Width corners: N_SRC=1 and N_SRC=32.
  - Source 31 pending and enabled gives IRQ_ID=32.
  - Write 32'hFFFFFFFF to ENABLE with N_SRC=1 reads back 1.
  - A=7 reads 0.
- With IRQ_CTRL_POLARITY_EN: POLARITY=8'h01, IRQ_IN[0] low, edge mode → PENDING[0]=1; RAW[0]=1. Without the macro, A=5 reads 0.
